// File: rtl/inst_mem_loader_if.sv
// rtl/inst_mem_loader_if.sv - byte-stream receive side and instruction-memory write port of the boot loader
`ifndef INST_MEM_ADDR_WIDTH
`define INST_MEM_ADDR_WIDTH 10
`endif
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

interface inst_mem_loader_if #(
    parameter int ADDR_WIDTH = `INST_MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = `CPU_WIDTH
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - boot-time instruction memory writer; LOADER_CHKSUM_EN adds a trailing checksum byte check
`ifndef INST_MEM_ADDR_WIDTH
`define INST_MEM_ADDR_WIDTH 10
`endif
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module inst_mem_loader #(
    parameter int ADDR_WIDTH = `INST_MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = `CPU_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   load_len,
    inst_mem_loader_if.master     bus,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHK, S_DONE} state_t;

`ifdef LOADER_CHKSUM_EN
    localparam state_t S_END = S_CHK;
`else
    localparam state_t S_END = S_DONE;
`endif

    state_t                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [23:0]           word_buf_q, word_buf_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_waddr_q, mem_waddr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
`ifdef LOADER_CHKSUM_EN
    logic [7:0]            sum_q, sum_d;
    logic                  err_q, err_d;
`endif

    logic                  rx_ready;
    logic                  accept;
    logic                  start_ok;
    logic                  last_byte;
    logic [ADDR_WIDTH:0]   word_cnt_inc;

    assign accept       = bus.rx_valid && rx_ready;
    assign start_ok     = start && (state_q == S_IDLE || state_q == S_DONE);
    assign word_cnt_inc = word_cnt_q + (ADDR_WIDTH+1)'(1);
    assign last_byte    = accept && (state_q == S_LOAD) && (byte_cnt_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = (load_len == '0) ? S_END : S_LOAD;
                end
            end
            S_LOAD: begin
                if (last_byte && word_cnt_inc == len_q) begin
                    state_d = S_END;
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready = (state_q == S_LOAD) || (state_q == S_CHK);
        done     = (state_q == S_DONE);
        cpu_hold = rx_ready || mem_we_q;
    end

    // Bytes 0..2 wait in word_buf; byte 3 completes the word straight into the write register.
    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        len_d       = len_q;
        word_buf_d  = word_buf_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        if (start_ok) begin
            byte_cnt_d = 2'd0;
            word_cnt_d = '0;
            len_d      = load_len;
        end else if (accept && state_q == S_LOAD) begin
            case (byte_cnt_q)
                2'd0: word_buf_d[7:0]   = bus.rx_data;
                2'd1: word_buf_d[15:8]  = bus.rx_data;
                2'd2: word_buf_d[23:16] = bus.rx_data;
                default: begin
                    mem_we_d    = 1'b1;
                    mem_waddr_d = word_cnt_q[ADDR_WIDTH-1:0];
                    mem_wdata_d = {bus.rx_data, word_buf_q};
                    word_cnt_d  = word_cnt_inc;
                end
            endcase
            byte_cnt_d = byte_cnt_q + 2'd1;
        end
    end

`ifdef LOADER_CHKSUM_EN
    always_comb begin
        sum_d = sum_q;
        err_d = err_q;
        if (start_ok) begin
            sum_d = 8'h00;
            err_d = 1'b0;
        end else if (accept && state_q == S_LOAD) begin
            sum_d = sum_q + bus.rx_data;
        end else if (accept && state_q == S_CHK) begin
            err_d = (bus.rx_data != sum_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 8'h00;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q  <= 2'd0;
            word_cnt_q  <= '0;
            len_q       <= '0;
            word_buf_q  <= 24'h0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            len_q       <= len_d;
            word_buf_q  <= word_buf_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.rx_ready  = rx_ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_waddr = mem_waddr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - directed table-driven bench for inst_mem_loader (LOADER_CHKSUM_EN aware)
`timescale 1ns/1ps

module tb_inst_mem_loader;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   load_len = '0;
    logic          cpu_hold;
    logic          done;
    logic          err;

    inst_mem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    inst_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .load_len (load_len),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    logic [31:0]   mem_model [DEPTH];
    logic [AW-1:0] wr_a [$];
    logic [31:0]   wr_d [$];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem_model[bus.mem_waddr] <= bus.mem_wdata;
            wr_a.push_back(bus.mem_waddr);
            wr_d.push_back(bus.mem_wdata);
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [AW:0] len);
        load_len = len;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // Leaves rx_valid high so consecutive calls stream with no bubble.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int k = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        while (!bus.rx_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.rx_ready) begin
            check("send_timeout", {31'h0, bus.rx_ready}, 32'h1);
            return;
        end
        @(posedge clk); #1;
        if (gap) begin
            bus.rx_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [AW:0]   len;
        logic [63:0]   bytes;
        bit            gap;
        int            exp_wr;
        logic [AW-1:0] exp_last_a;
        logic [31:0]   exp_first_d;
        logic [31:0]   exp_last_d;
    } vec_t;

    task automatic run_vector(input vec_t v, input string tag);
        int         base;
        int         n;
        logic [7:0] b;
        logic [7:0] sum;
        base = wr_a.size();
        sum  = 8'h00;
        n    = 4 * int'(v.len);
        do_start(v.len);
        if (v.len == 0) begin
`ifdef LOADER_CHKSUM_EN
            check({tag, "_len0_ready"}, {31'h0, bus.rx_ready}, 32'h1);
            check({tag, "_len0_done_early"}, {31'h0, done}, 32'h0);
            send_byte(8'h00, 1'b0);
            bus.rx_valid = 1'b0;
`endif
            check({tag, "_len0_done"}, {31'h0, done}, 32'h1);
            check({tag, "_len0_err"}, {31'h0, err}, 32'h0);
            check({tag, "_len0_we"}, {31'h0, bus.mem_we}, 32'h0);
`ifndef LOADER_CHKSUM_EN
            check({tag, "_len0_hold"}, {31'h0, cpu_hold}, 32'h0);
            check({tag, "_len0_ready"}, {31'h0, bus.rx_ready}, 32'h0);
`endif
        end else begin
            check({tag, "_start_ready"}, {31'h0, bus.rx_ready}, 32'h1);
            check({tag, "_start_hold"}, {31'h0, cpu_hold}, 32'h1);
            for (int i = 0; i < n; i++) begin
                b = (n <= 8) ? v.bytes[8*i +: 8] : 8'(i / 4);
                sum = sum + b;
                send_byte(b, v.gap && (i != n - 1));
            end
            bus.rx_valid = 1'b0;
            check({tag, "_last_we"}, {31'h0, bus.mem_we}, 32'h1);
            check({tag, "_last_hold"}, {31'h0, cpu_hold}, 32'h1);
`ifdef LOADER_CHKSUM_EN
            check({tag, "_chk_not_done"}, {31'h0, done}, 32'h0);
            send_byte(sum, 1'b0);
            bus.rx_valid = 1'b0;
            check({tag, "_chk_done"}, {31'h0, done}, 32'h1);
            check({tag, "_chk_err"}, {31'h0, err}, 32'h0);
`else
            check({tag, "_done"}, {31'h0, done}, 32'h1);
            @(posedge clk); #1;
            check({tag, "_hold_release"}, {31'h0, cpu_hold}, 32'h0);
            check({tag, "_err"}, {31'h0, err}, 32'h0);
`endif
            check({tag, "_we_low"}, {31'h0, bus.mem_we}, 32'h0);
            check({tag, "_done_level"}, {31'h0, done}, 32'h1);
        end
        check({tag, "_wr_count"}, 32'(wr_a.size() - base), 32'(v.exp_wr));
        if (v.exp_wr > 0 && wr_a.size() > base) begin
            check({tag, "_first_addr"}, 32'(wr_a[base]), 32'h0);
            check({tag, "_first_data"}, wr_d[base], v.exp_first_d);
            check({tag, "_last_addr"}, 32'(wr_a[wr_a.size()-1]), 32'(v.exp_last_a));
            check({tag, "_last_data"}, wr_d[wr_d.size()-1], v.exp_last_d);
        end
    endtask

    vec_t vecs [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{len: 5'd2, bytes: 64'h0010_0093_0000_0013, gap: 1'b0, exp_wr: 2,
                    exp_last_a: 4'd1, exp_first_d: 32'h0000_0013, exp_last_d: 32'h0010_0093};
        vecs[1] = '{len: 5'd2, bytes: 64'h0010_0093_0000_0013, gap: 1'b1, exp_wr: 2,
                    exp_last_a: 4'd1, exp_first_d: 32'h0000_0013, exp_last_d: 32'h0010_0093};
        vecs[2] = '{len: 5'd1, bytes: 64'h0000_0000_1234_5678, gap: 1'b0, exp_wr: 1,
                    exp_last_a: 4'd0, exp_first_d: 32'h1234_5678, exp_last_d: 32'h1234_5678};
        vecs[3] = '{len: 5'd0, bytes: 64'h0, gap: 1'b0, exp_wr: 0,
                    exp_last_a: 4'd0, exp_first_d: 32'h0, exp_last_d: 32'h0};
        vecs[4] = '{len: 5'd2, bytes: 64'hDEAD_BEEF_0403_0201, gap: 1'b1, exp_wr: 2,
                    exp_last_a: 4'd1, exp_first_d: 32'h0403_0201, exp_last_d: 32'hDEAD_BEEF};

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #12;
        check("rst_rx_ready", {31'h0, bus.rx_ready}, 32'h0);
        check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
        check("rst_mem_waddr", 32'(bus.mem_waddr), 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_cpu_hold", {31'h0, cpu_hold}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            run_vector(vecs[i], $sformatf("vec%0d", i));
            @(posedge clk); #1;
        end

        // Depth+1 words: the final word wraps onto address 0.
        begin
            vec_t w;
            w = '{len: 5'(DEPTH + 1), bytes: 64'h0, gap: 1'b0, exp_wr: DEPTH + 1,
                  exp_last_a: 4'd0, exp_first_d: 32'h0000_0000, exp_last_d: 32'h1010_1010};
            run_vector(w, "wrap");
            check("wrap_mem0", mem_model[0], 32'h1010_1010);
            check("wrap_mem15", mem_model[15], 32'h0F0F_0F0F);
        end

        // Async reset after five bytes; start during LOAD must be ignored first.
        do_start(5'd2);
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
        bus.rx_valid = 1'b0;
        load_len = 5'd0;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        check("ign_start_done", {31'h0, done}, 32'h0);
        check("ign_start_ready", {31'h0, bus.rx_ready}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'h0, bus.rx_ready}, 32'h0);
        check("mid_rst_hold", {31'h0, cpu_hold}, 32'h0);
        check("mid_rst_waddr", 32'(bus.mem_waddr), 32'h0);
        check("mid_rst_wdata", bus.mem_wdata, 32'h0);
        check("mid_rst_done", {31'h0, done}, 32'h0);
        check("mid_rst_mem0", mem_model[0], 32'h0403_0201);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        begin
            vec_t r;
            r = '{len: 5'd1, bytes: 64'h0000_0000_DDCC_BBAA, gap: 1'b0, exp_wr: 1,
                  exp_last_a: 4'd0, exp_first_d: 32'hDDCC_BBAA, exp_last_d: 32'hDDCC_BBAA};
            run_vector(r, "post_rst");
        end

`ifdef LOADER_CHKSUM_EN
        do_start(5'd1);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
        send_byte(8'h0A, 1'b0);
        bus.rx_valid = 1'b0;
        check("chk_good_done", {31'h0, done}, 32'h1);
        check("chk_good_err", {31'h0, err}, 32'h0);
        @(posedge clk); #1;
        do_start(5'd1);
        check("chk_restart_err_clr", {31'h0, err}, 32'h0);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
        send_byte(8'h0B, 1'b0);
        bus.rx_valid = 1'b0;
        check("chk_bad_done", {31'h0, done}, 32'h1);
        check("chk_bad_err", {31'h0, err}, 32'h1);
        @(posedge clk); #1;
        check("chk_bad_err_level", {31'h0, err}, 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Boot-time writer for the instruction memory. Accepts a byte stream (UART/debug link) under a valid/ready handshake, assembles little-endian 32-bit instruction words, and drives a one-word write port into the instruction memory array from word address 0 upward. It holds the core in reset while loading and reports completion, with an optional checksum check. It sits between the host link receiver and the instruction memory write side, beside the core's combinational fetch read port.

## Interface
- `ADDR_WIDTH`, default `` `INST_MEM_ADDR_WIDTH ``: word-address width of the instruction memory.
- `DATA_WIDTH`, default `` `CPU_WIDTH `` (32): instruction word width. Only 32 is supported.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle load request; sampled only in IDLE or DONE.
- `load_len`  in  ADDR_WIDTH+1: number of words to load; sampled with `start`.
- `rx_data`  in  8: stream byte.
- `rx_valid`  in  1: `rx_data` is valid.
- `rx_ready`  out  1: loader can accept a byte.
- `mem_we`  out  1: one-cycle write strobe to the instruction memory.
- `mem_waddr`  out  ADDR_WIDTH: word address of the write.
- `mem_wdata`  out  DATA_WIDTH: word to write.
- `cpu_hold`  out  1: core held in reset.
- `done`  out  1: load finished (level).
- `err`  out  1: checksum mismatch (level, valid while `done`=1).

## Operation
- States are IDLE, LOAD, CHK (checksum build only) and DONE.
- A byte is accepted on any edge where `rx_valid && rx_ready`. `rx_ready` = (state==LOAD || state==CHK).
- Bytes are packed little-endian into the word: byte 0 goes to [7:0] and byte 3 goes to [31:24]. A 2-bit byte counter tracks position in the word.
- On the edge that accepts byte 3:
  - register `mem_we`=1, `mem_wdata`=assembled word, and `mem_waddr`=word counter;
  - increment the word counter and clear the byte counter.
- `mem_we` is high for exactly one cycle per word.
- Word counter is ADDR_WIDTH+1 bits. `mem_waddr` is its low ADDR_WIDTH bits, so writes beyond the memory depth wrap to address 0.
- State transitions:
  - IDLE or DONE, `start`=1: go to LOAD; clear word counter, byte counter, checksum, `done` and `err`.
  - IDLE or DONE, `start`=1 with `load_len`=0: go straight to DONE (CHK if enabled). No write occurs.
  - LOAD, word counter reaches `load_len` on the final byte's edge: go to DONE (CHK if enabled).
  - `start` in LOAD or CHK is ignored.
- `cpu_hold` = (state==LOAD || state==CHK || `mem_we`). The final write is therefore covered.
- `done` = (state==DONE). `mem_wdata` and `mem_waddr` hold their last values between writes.

## Timing
- Reset values: state IDLE, `rx_ready`=0, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0, `cpu_hold`=0, `done`=0, `err`=0.
- `start` sampled at edge N: `rx_ready`=1 and `cpu_hold`=1 from cycle N+1.
- Byte 3 of a word accepted at edge M: `mem_we`=1 during cycle M+1; the memory captures the word at edge M+2's launch edge (M+1).
- Final byte accepted at edge M, no checksum: `done`=1, `mem_we`=1 and `cpu_hold`=1 during cycle M+1; `cpu_hold`=0 from cycle M+2.
- Back-to-back bytes are accepted every cycle with no bubbles.
- `rx_valid` low stalls the load indefinitely with no timeout.
- Async reset mid-load: immediate return to reset values. Partial words are discarded; words already written remain in memory.

## Configuration
- `` `LOADER_CHKSUM_EN `` defined:
  - an 8-bit running sum (mod 256) of all data bytes is kept;
  - after the last word the FSM enters CHK and accepts exactly one checksum byte;
  - on that edge it goes to DONE with `err` = (byte != sum).
  - With `load_len`=0 the expected sum is 0x00.
- Not defined: no CHK state, no sum register, `err` tied to 0.

## Test plan
- Load `load_len`=2 with bytes 13 00 00 00 93 00 10 00 -> writes 0x00000013 to addr 0 and 0x00100093 to addr 1. `mem_we` is high for one cycle each. `done`=1 one cycle after the last byte.
- `rx_valid` toggled every other cycle during the same load -> identical writes, no dropped or duplicated bytes.
- `load_len`=0 with `start` -> `done`=1 next cycle (CHK cycle if enabled); no `mem_we`; `cpu_hold` never high without checksum.
- `load_len` = depth+1 -> last word written to addr 0 (wrap); `done` asserted.
- `rst_n` pulsed low after 5 bytes -> all outputs return to 0 immediately; a new `start` restarts at addr 0.
- Checksum build, 4 bytes 01 02 03 04 then 0x0A -> `err`=0; repeat with 0x0B -> `err`=1, `done`=1.
